lo_hi_unit: RTL

Owns the architectural HI/LO register pair and executes MULT/MULTU iteratively in the execute stage. It sits directly downstream of the write-destination decoder and consumes its `writeLoHi` flag as `start`. Because multiplication takes several cycles, the block exports a stall request. The pipeline uses that stall to hold back MFHI/MFLO/MTHI/MTLO and back-to-back multiplies until HI/LO are final.

---
 rtl/lo_hi_unit_if.sv | 31 +++
 rtl/lo_hi_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/lo_hi_unit_if.sv
// Pipeline-facing signal bundle for the HI/LO multiply unit.
// The master side is the execute stage; the slave side is lo_hi_unit.
interface lo_hi_unit_if;
  // Handshake: start, mtHi, mtLo and readReq are requests held by the pipeline.
  // A request counts only in a cycle where stall is low. While stall is high the
  // pipeline keeps the same request on the bus and presents it again once busy falls.
  logic        start;
  logic        isSigned;
  logic [31:0] a;
  logic [31:0] b;
  logic        mtHi;
  logic        mtLo;
  logic [31:0] mtData;
  logic        readReq;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output start, isSigned, a, b, mtHi, mtLo, mtData, readReq, flush,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, isSigned, a, b, mtHi, mtLo, mtData, readReq, flush,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/lo_hi_unit.sv
// HI/LO register pair with an iterative shift-add MULT/MULTU engine.
// UNROLL multiplier bits are retired per RUN cycle; the sign is applied in WRITE.
module lo_hi_unit #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rstN,
  lo_hi_unit_if.slave  bus,
  output logic [1:0]   o_state
);
  localparam int ITERS = 32 / UNROLL;
  localparam int CW    = $clog2(ITERS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_mplier;
  logic [63:0]   r_mcand;
  logic [63:0]   r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_neg;
  logic          r_done;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic [31:0]   w_mag_a;
  logic [31:0]   w_mag_b;
  logic [63:0]   w_acc_next;
  logic [63:0]   w_product;
  logic          w_busy;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  assign w_mag_a = (bus.isSigned & bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign w_mag_b = (bus.isSigned & bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < UNROLL; k++) begin
      if (r_mplier[k]) begin
        w_acc_next = w_acc_next + (r_mcand << k);
      end
    end
  end

  assign w_product = r_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_busy    = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= S_IDLE;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else if (bus.start) begin
            r_mplier <= w_mag_b;
            r_mcand  <= {32'd0, w_mag_a};
            r_neg    <= bus.isSigned & (bus.a[31] ^ bus.b[31]);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            if (bus.mtHi) r_hi <= bus.mtData;
            if (bus.mtLo) r_lo <= bus.mtData;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> UNROLL;
            r_mcand  <= r_mcand << UNROLL;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == CW'(ITERS - 1)) r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!bus.flush) begin
            r_hi   <= w_product[63:32];
            r_lo   <= w_product[31:0];
            r_done <= 1'b1;
          end
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.stall = w_busy & (bus.start | bus.readReq | bus.mtHi | bus.mtLo);
  assign o_state   = r_state;
endmodule
